// File: rtl/mul_rs_dispatch_pkg.sv
// Shared types and constants for the mul/div reservation station.
// One rs_entry_t describes a station slot: operands, wakeup tags and relative age.
package mul_rs_dispatch_pkg;

    localparam int N_ENT = 3;
    localparam int DW    = 8;
    localparam int TAGW  = 3;
    localparam int REGW  = 4;
    localparam int FW    = 4;
    localparam int IDXW  = 3;
    localparam int AGEW  = 2;
    localparam int OCCW  = 2;

    localparam logic [FW-1:0] FUNC_MUL = 4'b0010;
    localparam logic [FW-1:0] FUNC_DIV = 4'b0011;

    typedef struct packed {
        logic            busy;
        logic            in_exec;
        logic [FW-1:0]   func;
        logic [REGW-1:0] rd;
        logic [TAGW-1:0] rob;
        logic            rdy1;
        logic [DW-1:0]   v1;
        logic [TAGW-1:0] tag1;
        logic            rdy2;
        logic [DW-1:0]   v2;
        logic [TAGW-1:0] tag2;
        logic [AGEW-1:0] age;
    } rs_entry_t;

    function automatic logic [OCCW-1:0] count_busy(input logic [N_ENT-1:0] busy);
        logic [OCCW-1:0] n;
        n = '0;
        for (int i = 0; i < N_ENT; i++) begin
            n = n + OCCW'(busy[i]);
        end
        return n;
    endfunction

    // True when a waiting operand is satisfied by the broadcast on the CDB.
    function automatic logic cdb_hit(input logic rdy, input logic [TAGW-1:0] tag,
                                     input logic cdb_valid, input logic [TAGW-1:0] cdb_tag);
        return !rdy && cdb_valid && (tag == cdb_tag);
    endfunction

endpackage

// File: rtl/mul_rs_dispatch_age_select.sv
// Combinational oldest-ready picker: returns the ready entry with the smallest age.
// Ages of busy entries are unique, so ties only arise between non-ready slots.
module rs_age_select
    import mul_rs_dispatch_pkg::*;
(
    input  logic [N_ENT-1:0]           ready,
    input  logic [N_ENT-1:0][AGEW-1:0] age,
    output logic [IDXW-1:0]            sel_idx,
    output logic                       found
);

    logic [AGEW-1:0] best_age;

    // NOTE: combinational blocks use blocking '=' so later statements see the updated value.
    always_comb begin
        // NOTE: every output gets a default first; a path that skips an assignment would infer a latch.
        found    = 1'b0;
        sel_idx  = '0;
        best_age = '0;
        for (int i = 0; i < N_ENT; i++) begin
            if (ready[i] && (!found || (age[i] < best_age))) begin
                found    = 1'b1;
                sel_idx  = IDXW'(i);
                best_age = age[i];
            end
        end
    end

endmodule

// File: rtl/mul_rs_dispatch.sv
// Mul/div reservation station: captures issued ops, snoops the CDB for operands,
// dispatches the oldest ready entry to the single execution unit and frees it on completion.
module mul_rs_dispatch
    import mul_rs_dispatch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,

    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [FW-1:0]   issue_func,
    input  logic [REGW-1:0] issue_rd,
    input  logic [TAGW-1:0] issue_rob,
    input  logic            issue_rdy1,
    input  logic            issue_rdy2,
    input  logic [DW-1:0]   issue_v1,
    input  logic [DW-1:0]   issue_v2,
    input  logic [TAGW-1:0] issue_tag1,
    input  logic [TAGW-1:0] issue_tag2,

    input  logic            cdb_valid,
    input  logic [TAGW-1:0] cdb_tag,
    input  logic [DW-1:0]   cdb_data,

    output logic            ex_start,
    output logic [IDXW-1:0] ex_rs_index,
    output logic [FW-1:0]   ex_func,
    output logic [REGW-1:0] ex_rd,
    output logic [TAGW-1:0] ex_rob,
    output logic [DW-1:0]   ex_rs1_data,
    output logic [DW-1:0]   ex_rs2_data,

    input  logic            done_valid,
    input  logic [IDXW-1:0] done_rs_index,

    output logic [OCCW-1:0] occupancy
);

    rs_entry_t ent_q [N_ENT];
    rs_entry_t ent_d [N_ENT];
    rs_entry_t new_ent;
    logic      unit_busy;

    logic [N_ENT-1:0]           busy_vec;
    logic [N_ENT-1:0]           ready_vec;
    logic [N_ENT-1:0][AGEW-1:0] age_vec;
    logic [OCCW-1:0]            occ;

    logic [IDXW-1:0] sel_idx;
    logic            sel_found;
    logic            dispatch_fire;
    logic [FW-1:0]   sel_func;
    logic [REGW-1:0] sel_rd;
    logic [TAGW-1:0] sel_rob;
    logic [DW-1:0]   sel_v1;
    logic [DW-1:0]   sel_v2;

    logic            free_hit;
    logic [AGEW-1:0] free_age;
    logic            alloc_fire;
    logic [IDXW-1:0] alloc_idx;

    always_comb begin
        for (int i = 0; i < N_ENT; i++) begin
            busy_vec[i]  = ent_q[i].busy;
            ready_vec[i] = ent_q[i].busy && ent_q[i].rdy1 && ent_q[i].rdy2 && !ent_q[i].in_exec;
            age_vec[i]   = ent_q[i].age;
        end
    end

    // Occupancy and issue_ready come from registered state only.
    assign occ         = count_busy(busy_vec);
    assign occupancy   = occ;
    assign issue_ready = (occ < OCCW'(N_ENT));

    rs_age_select u_age_select (
        .ready   (ready_vec),
        .age     (age_vec),
        .sel_idx (sel_idx),
        .found   (sel_found)
    );

    assign dispatch_fire = !unit_busy && sel_found;

    always_comb begin
        sel_func = '0;
        sel_rd   = '0;
        sel_rob  = '0;
        sel_v1   = '0;
        sel_v2   = '0;
        for (int i = 0; i < N_ENT; i++) begin
            if (sel_idx == IDXW'(i)) begin
                sel_func = ent_q[i].func;
                sel_rd   = ent_q[i].rd;
                sel_rob  = ent_q[i].rob;
                sel_v1   = ent_q[i].v1;
                sel_v2   = ent_q[i].v2;
            end
        end
    end

    // A completion only counts for an entry that is actually executing.
    always_comb begin
        free_hit = 1'b0;
        free_age = '0;
        for (int i = 0; i < N_ENT; i++) begin
            if (done_valid && (done_rs_index == IDXW'(i)) && ent_q[i].busy && ent_q[i].in_exec) begin
                free_hit = 1'b1;
                free_age = ent_q[i].age;
            end
        end
    end

    always_comb begin
        alloc_idx = '0;
        for (int i = N_ENT - 1; i >= 0; i--) begin
            if (!ent_q[i].busy) begin
                alloc_idx = IDXW'(i);
            end
        end
    end

    assign alloc_fire = issue_valid && issue_ready;

    // Incoming op, with operands captured straight off the CDB when the tag matches now.
    always_comb begin
        new_ent         = '0;
        new_ent.busy    = 1'b1;
        new_ent.func    = issue_func;
        new_ent.rd      = issue_rd;
        new_ent.rob     = issue_rob;
        new_ent.rdy1    = issue_rdy1;
        new_ent.v1      = issue_v1;
        new_ent.tag1    = issue_tag1;
        new_ent.rdy2    = issue_rdy2;
        new_ent.v2      = issue_v2;
        new_ent.tag2    = issue_tag2;
        new_ent.age     = AGEW'(occ - OCCW'(free_hit));
        if (cdb_hit(issue_rdy1, issue_tag1, cdb_valid, cdb_tag)) begin
            new_ent.rdy1 = 1'b1;
            new_ent.v1   = cdb_data;
        end
        if (cdb_hit(issue_rdy2, issue_tag2, cdb_valid, cdb_tag)) begin
            new_ent.rdy2 = 1'b1;
            new_ent.v2   = cdb_data;
        end
    end

    always_comb begin
        for (int i = 0; i < N_ENT; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].busy) begin
                if (cdb_hit(ent_q[i].rdy1, ent_q[i].tag1, cdb_valid, cdb_tag)) begin
                    ent_d[i].rdy1 = 1'b1;
                    ent_d[i].v1   = cdb_data;
                end
                if (cdb_hit(ent_q[i].rdy2, ent_q[i].tag2, cdb_valid, cdb_tag)) begin
                    ent_d[i].rdy2 = 1'b1;
                    ent_d[i].v2   = cdb_data;
                end
                if (free_hit && (ent_q[i].age > free_age)) begin
                    ent_d[i].age = ent_q[i].age - AGEW'(1);
                end
            end
            if (free_hit && (done_rs_index == IDXW'(i))) begin
                ent_d[i].busy    = 1'b0;
                ent_d[i].in_exec = 1'b0;
            end
            if (dispatch_fire && (sel_idx == IDXW'(i))) begin
                ent_d[i].in_exec = 1'b1;
            end
            if (alloc_fire && (alloc_idx == IDXW'(i))) begin
                ent_d[i] = new_ent;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the entry array is reset because busy/in_exec are live control state, not just data.
            for (int i = 0; i < N_ENT; i++) begin
                ent_q[i] <= '0;
            end
            unit_busy   <= 1'b0;
            ex_start    <= 1'b0;
            ex_rs_index <= '0;
            ex_func     <= '0;
            ex_rd       <= '0;
            ex_rob      <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
        end else begin
            for (int i = 0; i < N_ENT; i++) begin
                ent_q[i] <= ent_d[i];
            end
            ex_start <= dispatch_fire;
            if (dispatch_fire) begin
                unit_busy   <= 1'b1;
                ex_rs_index <= sel_idx;
                ex_func     <= sel_func;
                ex_rd       <= sel_rd;
                ex_rob      <= sel_rob;
                ex_rs1_data <= sel_v1;
                ex_rs2_data <= sel_v2;
            end else if (free_hit) begin
                unit_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mul_rs_dispatch.sv
// Directed bench for mul_rs_dispatch: an age-ordered queue model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_mul_rs_dispatch;
    import mul_rs_dispatch_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            issue_valid, issue_ready;
    logic [FW-1:0]   issue_func;
    logic [REGW-1:0] issue_rd;
    logic [TAGW-1:0] issue_rob, issue_tag1, issue_tag2;
    logic            issue_rdy1, issue_rdy2;
    logic [DW-1:0]   issue_v1, issue_v2;
    logic            cdb_valid;
    logic [TAGW-1:0] cdb_tag;
    logic [DW-1:0]   cdb_data;
    logic            ex_start;
    logic [IDXW-1:0] ex_rs_index;
    logic [FW-1:0]   ex_func;
    logic [REGW-1:0] ex_rd;
    logic [TAGW-1:0] ex_rob;
    logic [DW-1:0]   ex_rs1_data, ex_rs2_data;
    logic            done_valid;
    logic [IDXW-1:0] done_rs_index;
    logic [OCCW-1:0] occupancy;

    always #5 clk = ~clk;

    mul_rs_dispatch dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_func(issue_func),
        .issue_rd(issue_rd), .issue_rob(issue_rob), .issue_rdy1(issue_rdy1), .issue_rdy2(issue_rdy2),
        .issue_v1(issue_v1), .issue_v2(issue_v2), .issue_tag1(issue_tag1), .issue_tag2(issue_tag2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .ex_start(ex_start), .ex_rs_index(ex_rs_index), .ex_func(ex_func), .ex_rd(ex_rd),
        .ex_rob(ex_rob), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .done_valid(done_valid), .done_rs_index(done_rs_index), .occupancy(occupancy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending ops kept oldest-first; slot = station index the op occupies.
    typedef struct {
        int              slot;
        logic [FW-1:0]   func;
        logic [REGW-1:0] rd;
        logic [TAGW-1:0] rob;
        bit              r1;
        logic [DW-1:0]   v1;
        logic [TAGW-1:0] t1;
        bit              r2;
        logic [DW-1:0]   v2;
        logic [TAGW-1:0] t2;
        bit              exec;
    } op_t;

    op_t             mq[$];
    bit              m_unit;
    bit              m_start;
    int              m_idx;
    logic [FW-1:0]   m_func;
    logic [REGW-1:0] m_rd;
    logic [TAGW-1:0] m_rob;
    logic [DW-1:0]   m_d1, m_d2;

    always @(posedge clk or posedge rst) begin : model
        int  disp, fr, slot;
        bit  can_issue;
        bit  used [N_ENT];
        op_t o;
        if (rst) begin
            mq.delete();
            m_unit = 0; m_start = 0; m_idx = 0;
            m_func = '0; m_rd = '0; m_rob = '0; m_d1 = '0; m_d2 = '0;
        end else begin
            disp = -1; fr = -1; slot = -1;
            can_issue = (mq.size() < N_ENT);
            for (int k = 0; k < N_ENT; k++) used[k] = 0;
            for (int k = 0; k < mq.size(); k++) used[mq[k].slot] = 1;
            for (int k = N_ENT - 1; k >= 0; k--) if (!used[k]) slot = k;
            if (!m_unit)
                for (int k = 0; k < mq.size(); k++)
                    if (disp < 0 && mq[k].r1 && mq[k].r2 && !mq[k].exec) disp = k;
            if (done_valid)
                for (int k = 0; k < mq.size(); k++)
                    if (mq[k].exec && mq[k].slot == int'(done_rs_index)) fr = k;
            m_start = (disp >= 0);
            if (disp >= 0) begin
                o = mq[disp];
                m_idx = o.slot; m_func = o.func; m_rd = o.rd; m_rob = o.rob;
                m_d1 = o.v1; m_d2 = o.v2;
                o.exec = 1;
                mq[disp] = o;
                m_unit = 1;
            end
            if (cdb_valid)
                for (int k = 0; k < mq.size(); k++) begin
                    o = mq[k];
                    if (!o.r1 && o.t1 == cdb_tag) begin o.r1 = 1; o.v1 = cdb_data; end
                    if (!o.r2 && o.t2 == cdb_tag) begin o.r2 = 1; o.v2 = cdb_data; end
                    mq[k] = o;
                end
            if (fr >= 0) begin
                mq.delete(fr);
                m_unit = 0;
            end
            if (issue_valid && can_issue) begin
                o.slot = slot; o.func = issue_func; o.rd = issue_rd; o.rob = issue_rob;
                o.r1 = issue_rdy1; o.v1 = issue_v1; o.t1 = issue_tag1;
                o.r2 = issue_rdy2; o.v2 = issue_v2; o.t2 = issue_tag2;
                o.exec = 0;
                if (!o.r1 && cdb_valid && o.t1 == cdb_tag) begin o.r1 = 1; o.v1 = cdb_data; end
                if (!o.r2 && cdb_valid && o.t2 == cdb_tag) begin o.r2 = 1; o.v2 = cdb_data; end
                mq.push_back(o);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("cmp_ex_start",    32'(ex_start),    32'(m_start));
            check("cmp_ex_rs_index", 32'(ex_rs_index), 32'(m_idx));
            check("cmp_ex_func",     32'(ex_func),     32'(m_func));
            check("cmp_ex_rd",       32'(ex_rd),       32'(m_rd));
            check("cmp_ex_rob",      32'(ex_rob),      32'(m_rob));
            check("cmp_ex_rs1_data", 32'(ex_rs1_data), 32'(m_d1));
            check("cmp_ex_rs2_data", 32'(ex_rs2_data), 32'(m_d2));
            check("cmp_occupancy",   32'(occupancy),   32'(mq.size()));
            check("cmp_issue_ready", 32'(issue_ready), 32'(mq.size() < N_ENT));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clr_in();
        issue_valid = 0; issue_func = '0; issue_rd = '0; issue_rob = '0;
        issue_rdy1 = 0; issue_rdy2 = 0; issue_v1 = '0; issue_v2 = '0;
        issue_tag1 = '0; issue_tag2 = '0;
        cdb_valid = 0; cdb_tag = '0; cdb_data = '0;
        done_valid = 0; done_rs_index = '0;
    endtask

    task automatic set_issue(input logic [FW-1:0] func, input int rd, input int rob,
                             input int r1, input int v1, input int t1,
                             input int r2, input int v2, input int t2);
        issue_valid = 1; issue_func = func; issue_rd = REGW'(rd); issue_rob = TAGW'(rob);
        issue_rdy1 = r1[0]; issue_v1 = DW'(v1); issue_tag1 = TAGW'(t1);
        issue_rdy2 = r2[0]; issue_v2 = DW'(v2); issue_tag2 = TAGW'(t2);
    endtask

    task automatic set_cdb(input int tag, input int data);
        cdb_valid = 1; cdb_tag = TAGW'(tag); cdb_data = DW'(data);
    endtask

    task automatic free_slot(input int idx);
        done_valid = 1; done_rs_index = IDXW'(idx);
        tick();
        clr_in();
    endtask

    task automatic wait_start(input string name, input int budget);
        int n;
        n = 0;
        while (ex_start !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(ex_start), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr_in();
        rst = 1;
        repeat (2) tick();
        #1;
        check("rst_ex_start",    32'(ex_start),    32'd0);
        check("rst_ex_rs1_data", 32'(ex_rs1_data), 32'd0);
        check("rst_occupancy",   32'(occupancy),   32'd0);
        check("rst_issue_ready", 32'(issue_ready), 32'd1);
        tick();
        rst = 0;
        tick();

        // Single ready MUL: pulse two edges after issue.
        set_issue(FUNC_MUL, 3, 2, 1, 5, 0, 1, 7, 0);
        tick(); clr_in();
        check("t1_no_early",  32'(ex_start),  32'd0);
        check("t1_occ_one",   32'(occupancy), 32'd1);
        tick();
        check("t1_start",     32'(ex_start),    32'd1);
        check("t1_index",     32'(ex_rs_index), 32'd0);
        check("t1_rs1",       32'(ex_rs1_data), 32'd5);
        check("t1_rs2",       32'(ex_rs2_data), 32'd7);
        check("t1_rd",        32'(ex_rd),       32'd3);
        check("t1_rob",       32'(ex_rob),      32'd2);
        check("t1_func",      32'(ex_func),     32'(FUNC_MUL));
        tick();
        check("t1_pulse_end", 32'(ex_start),    32'd0);
        check("t1_hold",      32'(ex_rs1_data), 32'd5);
        free_slot(0);
        check("t1_freed_occ", 32'(occupancy), 32'd0);

        // DIV waiting on tag 4, woken by the CDB.
        set_issue(FUNC_DIV, 4, 3, 0, 0, 4, 1, 3, 0);
        tick(); clr_in();
        check("t2_wait_a", 32'(ex_start), 32'd0);
        tick();
        check("t2_wait_b", 32'(ex_start), 32'd0);
        set_cdb(4, 12);
        tick(); clr_in();
        check("t2_woken_not_yet", 32'(ex_start), 32'd0);
        tick();
        check("t2_start", 32'(ex_start),    32'd1);
        check("t2_rs1",   32'(ex_rs1_data), 32'd12);
        check("t2_rs2",   32'(ex_rs2_data), 32'd3);
        check("t2_func",  32'(ex_func),     32'(FUNC_DIV));
        tick();
        free_slot(0);

        // Operand 2 captured from the CDB in the issue cycle.
        set_issue(FUNC_MUL, 5, 4, 1, 2, 0, 0, 0, 5);
        set_cdb(5, 9);
        tick(); clr_in();
        check("t3_no_early", 32'(ex_start), 32'd0);
        tick();
        check("t3_start", 32'(ex_start),    32'd1);
        check("t3_rs1",   32'(ex_rs1_data), 32'd2);
        check("t3_rs2",   32'(ex_rs2_data), 32'd9);
        tick();
        free_slot(0);

        // Fill the station; order must follow issue order.
        set_issue(FUNC_MUL, 1, 1, 1, 1, 0, 1, 1, 0); tick();
        set_issue(FUNC_MUL, 2, 2, 1, 2, 0, 1, 2, 0); tick();
        set_issue(FUNC_MUL, 3, 3, 1, 3, 0, 1, 3, 0); tick();
        clr_in();
        check("t4_full_occ",   32'(occupancy),   32'd3);
        check("t4_not_ready",  32'(issue_ready), 32'd0);
        check("t4_first_rob",  32'(ex_rob),      32'd1);
        set_issue(FUNC_DIV, 7, 7, 1, 9, 0, 1, 9, 0);
        tick(); clr_in();
        check("t4_refused_occ", 32'(occupancy), 32'd3);
        free_slot(0);
        wait_start("t4_second_start", 4);
        check("t4_second_rob", 32'(ex_rob),      32'd2);
        check("t4_second_idx", 32'(ex_rs_index), 32'd1);
        tick();
        // Allocate into a new slot while slot 1 completes.
        set_issue(FUNC_MUL, 6, 6, 1, 6, 0, 1, 6, 0);
        done_valid = 1; done_rs_index = 3'd1;
        tick(); clr_in();
        check("t4_alloc_free_occ", 32'(occupancy), 32'd2);
        wait_start("t4_third_start", 4);
        check("t4_third_rob", 32'(ex_rob),      32'd3);
        check("t4_third_idx", 32'(ex_rs_index), 32'd2);
        tick();
        free_slot(2);
        wait_start("t4_fourth_start", 4);
        check("t4_fourth_rob", 32'(ex_rob),      32'd6);
        check("t4_fourth_idx", 32'(ex_rs_index), 32'd0);
        tick();
        free_slot(0);
        check("t4_empty", 32'(occupancy), 32'd0);

        // Older op waits; younger ready DIV-by-zero goes first.
        set_issue(FUNC_MUL, 1, 1, 0, 0, 6, 1, 4, 0); tick();
        set_issue(FUNC_DIV, 2, 2, 1, 8, 0, 1, 0, 0); tick();
        clr_in();
        wait_start("t5_first_start", 3);
        check("t5_first_rob", 32'(ex_rob),      32'd2);
        check("t5_first_idx", 32'(ex_rs_index), 32'd1);
        check("t5_div_zero",  32'(ex_rs2_data), 32'd0);
        tick();
        done_valid = 1; done_rs_index = 3'd0;
        tick();
        done_rs_index = 3'd5;
        tick(); clr_in();
        check("t5_ignored_done_occ", 32'(occupancy), 32'd2);
        set_cdb(6, 33);
        tick(); clr_in();
        tick();
        check("t5_blocked", 32'(ex_start), 32'd0);
        free_slot(1);
        check("t5_same_cycle_no_dispatch", 32'(ex_start), 32'd0);
        tick();
        check("t5_second_start", 32'(ex_start),    32'd1);
        check("t5_second_rob",   32'(ex_rob),      32'd1);
        check("t5_second_rs1",   32'(ex_rs1_data), 32'd33);
        check("t5_second_rs2",   32'(ex_rs2_data), 32'd4);
        tick();
        free_slot(0);

        // Asynchronous reset while an op is in execution and another is pending.
        set_issue(FUNC_MUL, 7, 5, 1, 3, 0, 1, 4, 0); tick();
        set_issue(FUNC_MUL, 8, 6, 1, 1, 0, 1, 1, 0); tick();
        clr_in();
        check("t6_in_exec", 32'(ex_start), 32'd1);
        #2 rst = 1;
        #1;
        check("t6_async_start", 32'(ex_start),    32'd0);
        check("t6_async_index", 32'(ex_rs_index), 32'd0);
        check("t6_async_rob",   32'(ex_rob),      32'd0);
        check("t6_async_rs1",   32'(ex_rs1_data), 32'd0);
        check("t6_async_rs2",   32'(ex_rs2_data), 32'd0);
        check("t6_async_occ",   32'(occupancy),   32'd0);
        tick();
        tick();
        check("t6_held_no_start", 32'(ex_start), 32'd0);
        rst = 0;
        tick();
        check("t6_after_occ",   32'(occupancy),   32'd0);
        check("t6_after_ready", 32'(issue_ready), 32'd1);
        check("t6_after_start", 32'(ex_start),    32'd0);
        set_issue(FUNC_MUL, 9, 2, 1, 11, 0, 1, 12, 0);
        tick(); clr_in();
        tick();
        check("t6_restart",     32'(ex_start),    32'd1);
        check("t6_restart_idx", 32'(ex_rs_index), 32'd0);
        tick();
        free_slot(0);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_rs_dispatch.md
Name: mul_rs_dispatch

Overview:
- Multiply/divide reservation station. Three entries sit between the issue stage and the mul/div execution unit.
- Captures issued mul/div ops with their operands or producer tags, and snoops the CDB to wake waiting operands.
- Dispatches the oldest ready entry to the single execution unit with a one-cycle start pulse.
- Frees the entry when the execution unit reports completion.

Parameters:
- N_ENT, 3, number of station entries (index width 3 bits).
- DW, 8, operand data width.
- TAGW, 3, ROB index width; used as the producer tag.
- REGW, 4, destination register index width.
- FW, 4, function code width (4'b0010 = MUL, 4'b0011 = DIV).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- issue_valid  in  1  issue stage presents an op.
- issue_ready  out  1  station can accept an op this cycle.
- issue_func  in  FW  function code.
- issue_rd  in  REGW  destination register.
- issue_rob  in  TAGW  ROB index of the op.
- issue_rdy1 / issue_rdy2  in  1 each  operand 1 / 2 value is valid.
- issue_v1 / issue_v2  in  DW each  operand values.
- issue_tag1 / issue_tag2  in  TAGW each  producer ROB tag when the operand is not ready.
- cdb_valid  in  1  result broadcast valid.
- cdb_tag  in  TAGW  ROB tag of the broadcast.
- cdb_data  in  DW  broadcast value; low DW bits of the result.
- ex_start  out  1  one-cycle dispatch pulse (drives ex_b).
- ex_rs_index  out  3  dispatched entry index.
- ex_func  out  FW  dispatched function code.
- ex_rd  out  REGW  dispatched destination register.
- ex_rob  out  TAGW  dispatched ROB index.
- ex_rs1_data / ex_rs2_data  out  DW each  dispatched operand values.
- done_valid  in  1  execution unit finished.
- done_rs_index  in  3  entry that finished.
- occupancy  out  2  number of busy entries.

Behaviour:
- Reset (async): all entries invalid, unit_busy=0, ex_start=0, all ex_* outputs 0, occupancy=0, issue_ready=1.
- Entry fields: busy, in_exec, func, rd, rob, rdy1, v1, tag1, rdy2, v2, tag2, age (0..N_ENT-1, 0 = oldest).
- issue_ready = (occupancy < N_ENT). It is driven from registered state only, so a same-cycle free does not raise it.
- Allocate (issue_valid && issue_ready):
  - Target is the lowest-index free entry.
  - age = current occupancy.
  - Operand CDB bypass: if an operand is not ready and cdb_valid && cdb_tag == that operand's tag, store cdb_data with rdy=1.
- CDB wakeup: each cycle, every busy entry with rdyN=0 and tagN == cdb_tag (cdb_valid=1) latches vN=cdb_data and sets rdyN=1. Both operands may wake in the same cycle.
- Ready: busy && rdy1 && rdy2 && !in_exec, evaluated on registered state. An entry woken in cycle t is first dispatchable in cycle t+1.
- Dispatch (registered):
  - Condition: unit_busy=0 and at least one ready entry.
  - Select the ready entry with minimum age.
  - Next edge: ex_start=1 for exactly one cycle, ex_* loaded from that entry, in_exec=1, unit_busy=1.
  - ex_* hold their value after the pulse.
- Completion (done_valid):
  - Clear busy/in_exec of entry done_rs_index; clear unit_busy; occupancy decrements.
  - Every busy entry with age > freed age decrements its age.
  - The freed entry may be reallocated the next cycle.
  - done_valid on a non-busy or non-in_exec index is ignored and leaves unit_busy unchanged.
- Simultaneous events:
  - Allocate and free in the same cycle: occupancy unchanged. The new entry's age = occupancy-1, computed after the decrement.
  - Completion and dispatch eligibility in the same cycle: no dispatch this cycle (unit_busy still registered 1); dispatch on the next cycle.
- DIV by zero is passed through unchanged; the execution unit owns the result.
- Reset mid-operation: in-flight dispatch is abandoned, all entries are cleared, and no ex_start is emitted.

Decomposition:
- Shared package holds:
  - function codes FUNC_MUL=4'b0010 and FUNC_DIV=4'b0011;
  - N_ENT, DW, TAGW, REGW;
  - the rs_entry_t struct.
- One natural sub-module: rs_age_select, a combinational minimum-age picker over the ready vector that returns index and found flag.

Test Plan:
- Single issue: issue MUL rd=3, rob=2, v1=5, v2=7, both ready, while idle. Required: ex_start pulses at cycle 2 with ex_rs1_data=5, ex_rs2_data=7, ex_rs_index=0. Then done_valid index 0 gives occupancy 0.
- Wakeup: issue DIV with op1 waiting on tag 4 and v2=3. Then cdb_valid, tag 4, data 12. Required: no dispatch before the CDB cycle; ex_start the cycle after the CDB with ex_rs1_data=12, ex_rs2_data=3.
- Bypass: issue with op2 tag 5 in the same cycle as CDB tag 5, data 9. Required: entry stored ready with v2=9; dispatch the following cycle.
- Full and order: issue 3 ready ops (rob 1, 2, 3) while the unit is busy. Required: issue_ready=0 and a 4th issue is refused. After each completion, dispatch order is rob 1, then 2, then 3.
- Age with out-of-order readiness: the older entry (rob 1) waits on a tag, the younger (rob 2) is ready. Required: rob 2 dispatches first. Once rob 1 wakes and the unit frees, rob 1 dispatches next.
- Reset mid-operation: assert rst while an entry is in_exec. Required: all outputs are 0 immediately (asynchronously), and after release issue_ready=1 and occupancy=0.
